shift_pipe: RTL and testbench

- Two-stage pipelined shift execution unit for the RV32I ALU.
- Accepts SLL/SRL/SRA requests over a valid/ready handshake and prepares the operands.
- Drives two instances of the team's existing LeftShifter barrel shifter, one for data and one for the fill mask.
- Registers the result for the writeback mux.
- Right shifts reuse the left-only shifter by bit-reversing the operand before the shift and the result after it.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/shift_pipe_lshift.sv | 22 ++
 rtl/shift_pipe.sv | 140 ++++++++++++++
 tb/tb_shift_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift opcode encoding, default datapath geometry
// and a bit-reversal helper used by the shift unit.
package alu_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_op_e;

  localparam int ALU_DEPTH = 5;
  localparam int ALU_WIDTH = 1 << ALU_DEPTH;

  // Widest operand bitrev() can handle; callers zero-extend into this.
  localparam int BITREV_MAX_W = 64;

  // Reverses the low w bits of x; w is a constant at every call site.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] x,
                                                      input int unsigned             w);
    logic [BITREV_MAX_W-1:0] r;
    r = {<<{x}};
    return r >> (BITREV_MAX_W - w);
  endfunction

endpackage

// File: rtl/shift_pipe_lshift.sv
// LeftShifter: logarithmic barrel shifter, shifts data_i left by shamt_i
// filling with zeros.
module LeftShifter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [DEPTH-1:0] shamt_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage [DEPTH+1];

  assign stage[0] = data_i;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    assign stage[g+1] = shamt_i[g] ? (stage[g] << (1 << g)) : stage[g];
  end

  assign data_o = stage[DEPTH];

endmodule

// File: rtl/shift_pipe.sv
// Two-stage pipelined SLL/SRL/SRA unit. Right shifts run through the
// left-only shifter by reversing the operand going in and the result coming out.
module shift_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = ALU_DEPTH,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [DEPTH-1:0] in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  if (WIDTH != (1 << DEPTH)) begin : g_bad_geometry
    $error("shift_pipe: WIDTH must equal 2**DEPTH");
  end
  if (WIDTH > BITREV_MAX_W) begin : g_bad_width
    $error("shift_pipe: WIDTH exceeds bitrev capacity");
  end

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    logic [BITREV_MAX_W-1:0] t;
    t = bitrev(BITREV_MAX_W'(x), WIDTH);
    return t[WIDTH-1:0];
  endfunction

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_prep_q;
  logic [DEPTH-1:0] s1_shamt_q;
  shift_op_e        s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_sign_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_illegal_q;

  logic             s2_adv;
  logic             in_fire;
  shift_op_e        in_op_e;
  logic [WIDTH-1:0] prep_d;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] msk;
  logic [WIDTH-1:0] result_d;

  // in_ready sees out_ready combinationally through s2_adv.
  assign s2_adv   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign in_op_e  = shift_op_e'(in_op);

  always_comb begin
    prep_d = in_data;
    if (in_op_e == SHIFT_SRL || in_op_e == SHIFT_SRA) prep_d = rev(in_data);
  end

  // ---- S1: operand preparation ----
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
    end else if (s2_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_prep_q  <= prep_d;
      s1_shamt_q <= in_shamt;
      s1_op_q    <= in_op_e;
      s1_tag_q   <= in_tag;
      s1_sign_q  <= in_data[WIDTH-1];
    end
  end

  LeftShifter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_data_shift (
    .data_i  (s1_prep_q),
    .shamt_i (s1_shamt_q),
    .data_o  (sh)
  );

  LeftShifter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mask_shift (
    .data_i  ({WIDTH{1'b1}}),
    .shamt_i (s1_shamt_q),
    .data_o  (msk)
  );

  // Reversed mask has zeros in the vacated top bits; inverting it gives the sign fill.
  always_comb begin
    result_d = sh;
    unique case (s1_op_q)
      SHIFT_SLL:  result_d = sh;
      SHIFT_SRL:  result_d = rev(sh);
      SHIFT_SRA:  result_d = rev(sh) | (s1_sign_q ? ~rev(msk) : '0);
      SHIFT_RSVD: result_d = s1_prep_q;
      default:    result_d = sh;
    endcase
  end

  // ---- S2: result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_illegal_q <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q   <= 1'b1;
      out_result_q  <= result_d;
      out_tag_q     <= s1_tag_q;
      out_illegal_q <= (s1_op_q == SHIFT_RSVD);
    end else if (out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_illegal_q;

  a_in_stable: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> (!in_valid || $stable({in_op, in_data, in_shamt, in_tag})))
    else $error("shift_pipe: request payload changed while stalled");

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed shifts, streaming, backpressure, reset
// and randomised traffic against a scoreboard of reference results.
module tb_shift_pipe;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int D = 5;
  localparam int T = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_data;
  logic [D-1:0] in_shamt;
  logic [T-1:0] in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [T-1:0] out_tag;
  logic         out_illegal;

  shift_pipe #(.WIDTH(W), .DEPTH(D), .TAG_W(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_data     (in_data),
    .in_shamt    (in_shamt),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [T-1:0] tag;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;
  int   nout   = 0;

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] d,
                                         input logic [D-1:0] s);
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return W'($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        nout++;
        chk("sb_has_entry", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_result", out_result, mon_e.res);
          chk("sb_tag", W'(out_tag), W'(mon_e.tag));
          chk("sb_illegal", W'(out_illegal), W'(mon_e.ill));
        end
      end
      if (in_valid && in_ready)
        sb.push_back('{res: model(in_op, in_data, in_shamt), tag: in_tag, ill: (in_op == 2'b11)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [W-1:0] d, input logic [D-1:0] s,
                       input logic [T-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    in_tag   = tag;
  endtask

  // One request into an empty pipe with out_ready=1; checks latency and result.
  task automatic send1(input logic [1:0] op, input logic [W-1:0] d, input logic [D-1:0] s,
                       input logic [T-1:0] tag, input logic [W-1:0] exp_res, input logic exp_ill);
    drive(op, d, s, tag);
    tick();
    in_valid = 1'b0;
    chk("lat_not_early", W'(out_valid), W'(0));
    tick();
    chk("lat_valid", W'(out_valid), W'(1));
    chk("dir_tag", W'(out_tag), W'(tag));
    chk("dir_result", out_result, exp_res);
    chk("dir_illegal", W'(out_illegal), W'(exp_ill));
    tick();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    chk("drain_empty", W'(sb.size()), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int acc;
    int k;
    logic held;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_data = '0; in_shamt = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_result", out_result, W'(0));
    chk("rst_out_tag", W'(out_tag), W'(0));
    chk("rst_out_illegal", W'(out_illegal), W'(0));
    rst = 1'b0;
    tick();
    chk("rst_in_ready", W'(in_ready), W'(1));

    send1(2'b00, 32'h0000_0001, 5'd31, 5'd1, 32'h8000_0000, 1'b0);
    send1(2'b01, 32'h8000_0000, 5'd31, 5'd2, 32'h0000_0001, 1'b0);
    send1(2'b10, 32'h8000_0000, 5'd4,  5'd3, 32'hF800_0000, 1'b0);
    send1(2'b10, 32'h7FFF_FFF0, 5'd4,  5'd4, 32'h07FF_FFFF, 1'b0);
    send1(2'b00, 32'hDEAD_BEEF, 5'd0,  5'd5, 32'hDEAD_BEEF, 1'b0);
    send1(2'b01, 32'hDEAD_BEEF, 5'd0,  5'd6, 32'hDEAD_BEEF, 1'b0);
    send1(2'b10, 32'hDEAD_BEEF, 5'd0,  5'd7, 32'hDEAD_BEEF, 1'b0);
    send1(2'b11, 32'h1234_5678, 5'd9,  5'd8, 32'h1234_5678, 1'b1);

    // Streaming: 16 back-to-back requests.
    n0 = nout;
    for (int i = 0; i < 18; i++) begin
      if (i >= 2) chk("stream_out_valid", W'(out_valid), W'(1));
      if (i < 16) begin
        drive(2'(i % 3), 32'hA5A5_0000 + W'(i * 32'h1357), 5'(i * 3), 5'(i));
        chk("stream_in_ready", W'(in_ready), W'(1));
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    chk("stream_gap_after", W'(out_valid), W'(0));
    chk("stream_count", W'(nout - n0), W'(16));

    // Backpressure: hold output, offer requests until stalled.
    n0 = nout; acc = 0; k = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(2'(k % 3), 32'hC000_0000 | W'(k * 32'h11), 5'(k + 1), 5'(20 + k));
      @(negedge clk);
      if (in_ready) begin acc++; k++; end
      tick();
    end
    chk("bp_accepted", W'(acc), W'(2));
    chk("bp_in_ready_low", W'(in_ready), W'(0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(10);
    tick();
    chk("bp_drained_count", W'(nout - n0), W'(2));

    // Reset with both stages occupied.
    out_ready = 1'b0;
    drive(2'b00, 32'h0F0F_0F0F, 5'd1, 5'd29);
    tick();
    drive(2'b01, 32'hF0F0_F0F0, 5'd2, 5'd30);
    tick();
    in_valid = 1'b0;
    chk("rf_full_out_valid", W'(out_valid), W'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_out_valid", W'(out_valid), W'(0));
    chk("rf_out_result", out_result, W'(0));
    chk("rf_out_tag", W'(out_tag), W'(0));
    chk("rf_in_ready", W'(in_ready), W'(1));
    n0 = nout;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("rf_no_stale_out", W'(nout - n0), W'(0));

    // Random traffic with stalls on both sides.
    held = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 2'($urandom);
        in_data  = $urandom;
        in_shamt = 5'($urandom);
        in_tag   = 5'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      held = in_valid && !in_ready;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
